// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO special-register sequencer: owns HI/LO, runs one-bit-per-cycle MULT/DIV,
// executes MTHI/MTLO, supplies MFHI/MFLO data and stalls the pipe on collisions.
module hilo_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             read_hi,
  input  logic             read_lo,
  output logic [WIDTH-1:0] hilo_out,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] hi, lo;
  logic [WIDTH-1:0] acc_hi, acc_lo;   // mul: {upper, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0] b_reg;            // mul: multiplicand; div: divisor
  logic [WIDTH-1:0] a_raw;            // untouched dividend, returned in HI on divide-by-zero
  logic [CW-1:0]    cnt;
  logic             is_div, neg_q, neg_r, zero_div;

  // Decode of the issuing op (only meaningful when op[2] == 0)
  logic             op_muldiv, op_signed, op_div;
  logic [WIDTH-1:0] abs_a, abs_b;

  // Iteration datapath
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign op_muldiv = ~op[2];
  assign op_signed = op[0];
  assign op_div    = op[1];
  assign abs_a     = (op_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign abs_b     = (op_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_reg} : '0);
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_reg};
  // The true difference is below the divisor, so the low WIDTH bits are exact.
  assign div_rem   = div_shift[WIDTH-1:0] - b_reg;

  assign prod_fix  = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quot_fix  = neg_q ? -acc_lo : acc_lo;
  assign rem_fix   = neg_r ? -acc_hi : acc_hi;

  assign busy  = (state != IDLE);
  assign stall = busy & (read_hi | read_lo | start);

  always_comb begin
    hilo_out = '0;
    if (read_hi)      hilo_out = hi;
    else if (read_lo) hilo_out = lo;
  end

  // NOTE: every register here uses <= so all state advances from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      b_reg    <= '0;
      a_raw    <= '0;
      cnt      <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      zero_div <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op_muldiv) begin
              state    <= CALC;
              cnt      <= '0;
              is_div   <= op_div;
              neg_q    <= op_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
              neg_r    <= op_signed & operand_a[WIDTH-1];
              zero_div <= op_div & (operand_b == '0);
              a_raw    <= operand_a;
              acc_hi   <= '0;
              acc_lo   <= op_div ? abs_a : abs_b;
              b_reg    <= op_div ? abs_b : abs_a;
            end else if (op == OP_MTHI) begin
              hi <= operand_a;
            end else if (op == OP_MTLO) begin
              lo <= operand_a;
            end
          end
        end
        CALC: begin
          if (is_div) begin
            acc_hi <= div_ge ? div_rem : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            {hi, lo} <= prod_fix;
          end else if (zero_div) begin
            hi <= a_raw;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
          done     <= 1'b1;
          div_zero <= zero_div;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: vector table of mul/div ops through a
// result scoreboard, plus hand sequences for stall, back-to-back, MTHI/MTLO and reset.
module tb_hilo_muldiv_ctrl;
  localparam int W = 32;

  localparam logic [2:0] MULTU = 3'b000;
  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] DIVU  = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic         read_hi;
  logic         read_lo;
  logic [W-1:0] hilo_out;
  logic         stall;
  logic         busy;
  logic         done;
  logic         div_zero;

  hilo_muldiv_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .read_hi   (read_hi),
    .read_lo   (read_lo),
    .hilo_out  (hilo_out),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } vec_t;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[12];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
    exp_t e;
    start     = 1'b1;
    op        = o;
    operand_a = a;
    operand_b = b;
    e.hi = hi;
    e.lo = lo;
    e.dz = dz;
    exp_q.push_back(e);
  endtask

  // Called in the first cycle after accept; returns cycles since accept and busy count.
  task automatic wait_done(input string name, output int lat, output int nbusy);
    lat   = 1;
    nbusy = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    check({name, "_done_seen"}, done, 1'b1);
  endtask

  // Called in the done cycle: pop the scoreboard and read HI/LO through the MF port.
  task automatic check_result(input string name);
    exp_t e;
    check({name, "_sb_nonempty"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({name, "_div_zero"}, div_zero, e.dz);
      read_hi = 1'b1;
      #1;
      check({name, "_hi"}, hilo_out, e.hi);
      read_hi = 1'b0;
      read_lo = 1'b1;
      #1;
      check({name, "_lo"}, hilo_out, e.lo);
      read_lo = 1'b0;
    end
  endtask

  initial begin
    int lat, nb, n, ndone;

    vecs[0]  = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{MULTU, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0};
    vecs[6]  = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[7]  = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{DIV,   32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[9]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[10] = '{MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[11] = '{MULT,  32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};

    rst = 1'b1; start = 1'b0; op = 3'b000; operand_a = '0; operand_b = '0;
    read_hi = 1'b0; read_lo = 1'b0;
    repeat (2) tick();

    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_div_zero", div_zero, 1'b0);
    check("rst_stall", stall, 1'b0);
    read_hi = 1'b1; #1;
    check("rst_hi", hilo_out, '0);
    read_hi = 1'b0; read_lo = 1'b1; #1;
    check("rst_lo", hilo_out, '0);
    read_lo = 1'b0;
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz);
      tick();
      start = 1'b0;
      op    = 3'b000;
      wait_done($sformatf("v%0d", i), lat, nb);
      check($sformatf("v%0d_latency", i), lat, 34);
      check($sformatf("v%0d_busy_cycles", i), nb, 33);
      check_result($sformatf("v%0d", i));
      tick();
      check($sformatf("v%0d_done_one_cycle", i), done, 1'b0);
    end

    // MFLO held from the cycle after accept: stall covers CALC and FIX.
    issue(MULTU, 32'd6, 32'd7, 32'd0, 32'h2A, 1'b0);
    tick();
    start   = 1'b0;
    read_lo = 1'b1;
    #1;
    n = 0;
    while (stall && n < 100) begin
      n++;
      tick();
    end
    check("stall_cycles", n, 33);
    check("stall_release_lo", hilo_out, 32'h2A);
    check("stall_release_done", done, 1'b1);
    read_hi = 1'b1; #1;
    check("stall_both_reads_hi", hilo_out, 32'h0);
    read_hi = 1'b0; read_lo = 1'b0;
    check_result("stall_op");
    tick();

    // Second op held on the bus while the first is still running.
    issue(MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    tick();
    start = 1'b0;
    tick();
    tick();
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    #1;
    check("b2b_stall", stall, 1'b1);
    wait_done("b2b_first", lat, nb);
    check("b2b_release_stall", stall, 1'b0);
    check_result("b2b_first");
    tick();
    start = 1'b0;
    check("b2b_second_accepted", busy, 1'b1);
    wait_done("b2b_second", lat, nb);
    check("b2b_second_latency", lat, 34);
    check_result("b2b_second");
    tick();

    // MTHI, then MTLO with a same-cycle MFLO returning the old LO.
    start = 1'b1; op = MTHI; operand_a = 32'h1234;
    #1;
    check("mthi_busy_issue", busy, 1'b0);
    tick();
    start = 1'b0;
    check("mthi_busy_after", busy, 1'b0);
    read_hi = 1'b1; #1;
    check("mthi_value", hilo_out, 32'h1234);
    read_hi = 1'b0;
    start = 1'b1; op = MTLO; operand_a = 32'h55; read_lo = 1'b1;
    #1;
    check("mtlo_old_value", hilo_out, 32'd14);
    tick();
    start = 1'b0;
    check("mtlo_new_value", hilo_out, 32'h55);
    check("mtlo_no_done", done, 1'b0);
    read_lo = 1'b0;

    // Unlisted opcode is ignored.
    start = 1'b1; op = 3'b110; operand_a = 32'hDEAD;
    tick();
    start = 1'b0;
    tick();
    check("noop_busy", busy, 1'b0);
    read_hi = 1'b1; #1;
    check("noop_hi_kept", hilo_out, 32'h1234);
    read_hi = 1'b0;

    // Reset in the middle of CALC aborts with no result and no done pulse.
    start = 1'b1; op = MULTU; operand_a = 32'hFFFFFFFF; operand_b = 32'hFFFFFFFF;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("midrst_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 1'b0);
    read_hi = 1'b1; #1;
    check("midrst_hi", hilo_out, '0);
    read_hi = 1'b0; read_lo = 1'b1; #1;
    check("midrst_lo", hilo_out, '0);
    read_lo = 1'b0;
    ndone = 0;
    repeat (40) begin
      tick();
      if (done || busy) ndone++;
    end
    check("midrst_no_done", ndone, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
